// File: rtl/rs_fu_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_fu_issue_scheduler
// Description : Registered, fairness-aware matcher of ready reservation-station
//               entries to free functional units. A rotating round-robin start
//               pointer orders the RS scan. Per-FU busy countdown counters stop
//               a multi-cycle, non-pipelined FU from being re-issued too early.
//               Grants are registered and appear on the outputs one cycle after
//               the decision is made.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_fu_issue_scheduler #(
    parameter int NUM_OF_RS    = 8,
    parameter int NUM_OF_FU    = 2,
    parameter int FU_IDX_WIDTH = (NUM_OF_FU <= 1) ? 1 : $clog2(NUM_OF_FU),
    parameter int RS_IDX_WIDTH = (NUM_OF_RS <= 1) ? 1 : $clog2(NUM_OF_RS),
    parameter int LAT_WIDTH    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [NUM_OF_RS-1:0]              rs_ready,
    input  logic [NUM_OF_RS*LAT_WIDTH-1:0]    rs_latency,
    input  logic [NUM_OF_FU-1:0]              fu_enable,
    output logic [NUM_OF_RS-1:0]              rs_dispatch_en,
    output logic [NUM_OF_RS*FU_IDX_WIDTH-1:0] rs_fu_assign,
    output logic [NUM_OF_FU-1:0]              fu_issue_valid,
    output logic [NUM_OF_FU*RS_IDX_WIDTH-1:0] fu_issue_rs_idx,
    output logic [NUM_OF_FU-1:0]              fu_busy,
    output logic [RS_IDX_WIDTH-1:0]           rr_ptr
);

    // One extra bit so that rr_ptr + offset never overflows before the wrap.
    localparam int                  c_SCAN_W   = RS_IDX_WIDTH + 1;
    localparam logic [c_SCAN_W-1:0] c_NUM_RS_X = c_SCAN_W'(NUM_OF_RS);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [NUM_OF_RS-1:0]              r_dispatch_en;
    logic [NUM_OF_RS*FU_IDX_WIDTH-1:0] r_fu_assign;
    logic [NUM_OF_FU-1:0]              r_issue_valid;
    logic [NUM_OF_FU*RS_IDX_WIDTH-1:0] r_issue_rs_idx;
    logic [LAT_WIDTH-1:0]              r_busy_cnt [NUM_OF_FU];
    logic [RS_IDX_WIDTH-1:0]           r_rr_ptr;

    // ------------------------------------------------------------------
    // Combinational matching results
    // ------------------------------------------------------------------
    logic [NUM_OF_FU-1:0]              w_fu_free;
    logic [NUM_OF_FU-1:0]              w_fu_avail;
    logic [NUM_OF_RS-1:0]              w_nxt_dispatch;
    logic [NUM_OF_RS*FU_IDX_WIDTH-1:0] w_nxt_assign;
    logic [NUM_OF_FU-1:0]              w_nxt_valid;
    logic [NUM_OF_FU*RS_IDX_WIDTH-1:0] w_nxt_rs_idx;
    logic [LAT_WIDTH-1:0]              w_busy_load [NUM_OF_FU];
    logic [LAT_WIDTH-1:0]              w_lat;
    logic [c_SCAN_W-1:0]               w_scan_sum;
    logic [RS_IDX_WIDTH-1:0]           w_scan_idx;
    logic                              w_found;
    logic                              w_any_grant;
    logic [RS_IDX_WIDTH-1:0]           w_last_idx;
    logic [c_SCAN_W-1:0]               w_rr_sum;
    logic [RS_IDX_WIDTH-1:0]           w_nxt_rr;

    // An FU can accept work only when enabled and its occupancy has drained.
    generate
        for (genvar g = 0; g < NUM_OF_FU; g++) begin : g_fu_state
            assign w_fu_free[g] = fu_enable[g] && (r_busy_cnt[g] == '0);
            assign fu_busy[g]   = (r_busy_cnt[g] != '0);
        end
    endgenerate

    // Scan RS entries from rr_ptr; each candidate takes the lowest free FU left.
    always_comb begin
        w_fu_avail     = w_fu_free;
        w_nxt_dispatch = '0;
        w_nxt_assign   = '0;
        w_nxt_valid    = '0;
        w_nxt_rs_idx   = '0;
        w_any_grant    = 1'b0;
        w_last_idx     = '0;
        w_lat          = '0;
        w_scan_sum     = '0;
        w_scan_idx     = '0;
        w_found        = 1'b0;
        for (int f = 0; f < NUM_OF_FU; f++) begin
            w_busy_load[f] = '0;
        end
        for (int k = 0; k < NUM_OF_RS; k++) begin
            w_scan_sum = {1'b0, r_rr_ptr} + c_SCAN_W'(k);
            if (w_scan_sum >= c_NUM_RS_X) begin
                w_scan_sum = w_scan_sum - c_NUM_RS_X;
            end
            w_scan_idx = w_scan_sum[RS_IDX_WIDTH-1:0];
            w_lat      = rs_latency[w_scan_idx*LAT_WIDTH +: LAT_WIDTH];
            w_found    = 1'b0;
            // An entry already dispatching this cycle is masked to avoid re-issue.
            if (rs_ready[w_scan_idx] && !r_dispatch_en[w_scan_idx]) begin
                for (int f = 0; f < NUM_OF_FU; f++) begin
                    if (!w_found && w_fu_avail[f]) begin
                        w_found                  = 1'b1;
                        w_fu_avail[f]            = 1'b0;
                        w_nxt_valid[f]           = 1'b1;
                        w_nxt_dispatch[w_scan_idx] = 1'b1;
                        w_nxt_rs_idx[f*RS_IDX_WIDTH +: RS_IDX_WIDTH] = w_scan_idx;
                        w_nxt_assign[w_scan_idx*FU_IDX_WIDTH +: FU_IDX_WIDTH] =
                            FU_IDX_WIDTH'(f);
                        // A latency of 0 behaves like 1: free again next cycle.
                        w_busy_load[f] = (w_lat == '0) ? '0 : (w_lat - LAT_WIDTH'(1));
                        w_any_grant    = 1'b1;
                        w_last_idx     = w_scan_idx;
                    end
                end
            end
        end
    end

    // Next round-robin start: one past the last granted entry, with wrap.
    always_comb begin
        w_rr_sum = {1'b0, w_last_idx} + c_SCAN_W'(1);
        if (w_rr_sum >= c_NUM_RS_X) begin
            w_rr_sum = w_rr_sum - c_NUM_RS_X;
        end
        w_nxt_rr = w_any_grant ? w_rr_sum[RS_IDX_WIDTH-1:0] : r_rr_ptr;
    end

    // Register grants, run busy counters and advance the pointer; flush clears all.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_dispatch_en  <= '0;
            r_fu_assign    <= '0;
            r_issue_valid  <= '0;
            r_issue_rs_idx <= '0;
            r_rr_ptr       <= '0;
            for (int f = 0; f < NUM_OF_FU; f++) begin
                r_busy_cnt[f] <= '0;
            end
        end else begin
            r_dispatch_en  <= w_nxt_dispatch;
            r_fu_assign    <= w_nxt_assign;
            r_issue_valid  <= w_nxt_valid;
            r_issue_rs_idx <= w_nxt_rs_idx;
            r_rr_ptr       <= w_nxt_rr;
            for (int f = 0; f < NUM_OF_FU; f++) begin
                if (w_nxt_valid[f]) begin
                    r_busy_cnt[f] <= w_busy_load[f];
                end else if (r_busy_cnt[f] != '0) begin
                    r_busy_cnt[f] <= r_busy_cnt[f] - LAT_WIDTH'(1);
                end
            end
        end
    end

    assign rs_dispatch_en  = r_dispatch_en;
    assign rs_fu_assign    = r_fu_assign;
    assign fu_issue_valid  = r_issue_valid;
    assign fu_issue_rs_idx = r_issue_rs_idx;
    assign rr_ptr          = r_rr_ptr;

endmodule
`default_nettype wire

// File: doc/rs_fu_issue_scheduler.md
Name: rs_fu_issue_scheduler

Overview:
- Registered, fairness-aware successor to the combinational RS-to-FU scheduler.
- Each cycle it matches ready reservation-station entries to free functional units using a rotating round-robin start pointer instead of fixed lowest-index priority.
- Tracks per-FU occupancy with busy countdown counters, so multi-cycle non-pipelined FUs are not re-issued early.
- Sits between the RS array and the FU bank; outputs drive RS operand read-out and FU input muxes one cycle after the decision.

Parameters:
- NUM_OF_RS, 8: number of reservation-station entries.
- NUM_OF_FU, 2: number of functional units.
- FU_IDX_WIDTH, (NUM_OF_FU<=1)?1:$clog2(NUM_OF_FU): FU index width.
- RS_IDX_WIDTH, (NUM_OF_RS<=1)?1:$clog2(NUM_OF_RS): RS index width.
- LAT_WIDTH, 4: width of per-op FU occupancy latency.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- rs_ready  in  NUM_OF_RS  entry has all operands and requests issue.
- rs_latency  in  LAT_WIDTH x NUM_OF_RS  FU occupancy cycles of entry's op; 0 is treated as 1.
- fu_enable  in  NUM_OF_FU  FU present/enabled mask.
- rs_dispatch_en  out  NUM_OF_RS  registered; entry issued this cycle.
- rs_fu_assign  out  FU_IDX_WIDTH x NUM_OF_RS  registered; FU for each dispatched entry, 0 when not dispatched.
- fu_issue_valid  out  NUM_OF_FU  registered; FU receives an op this cycle.
- fu_issue_rs_idx  out  RS_IDX_WIDTH x NUM_OF_FU  registered; source RS entry, 0 when invalid.
- fu_busy  out  NUM_OF_FU  busy counter for FU is non-zero.
- rr_ptr  out  RS_IDX_WIDTH  current round-robin start index (debug/verification).

Behaviour:
- Reset (rst high at posedge): all registered outputs 0, all busy counters 0, rr_ptr 0. rst has priority over flush.
- Eligibility in cycle N:
  - FU f free iff fu_enable[f] && busy_cnt[f]==0.
  - RS r candidate iff rs_ready[r] && !rs_dispatch_en[r]. The currently-dispatching entry is masked, so its still-high ready never causes a double issue.
- Matching (combinational in cycle N):
  - Scan RS indices rr_ptr, rr_ptr+1, ... mod NUM_OF_RS, once each.
  - Each candidate takes the lowest-index free, not-yet-taken FU.
  - Scan stops granting when no free FU remains. Each FU gets at most one grant per cycle.
- Latency: grants decided in cycle N are registered and visible on all outputs in cycle N+1 for exactly one cycle.
- Busy counter:
  - On a grant to FU f, busy_cnt[f] <= max(rs_latency[r],1) - 1.
  - Otherwise it decrements by 1 when non-zero.
  - Net effect: latency 1 allows back-to-back issue every cycle; latency L allows issue every L cycles.
  - fu_busy[f] = (busy_cnt[f]!=0).
- Round robin: if at least one grant in cycle N, rr_ptr <= (last granted RS index in scan order + 1) mod NUM_OF_RS; otherwise unchanged. Wrap from NUM_OF_RS-1 goes to 0.
- fu_enable deasserted while an FU is busy: the counter still runs down, and no grant is made while enable is low.
- flush high at posedge:
  - No grants are made that cycle.
  - All registered outputs go to 0, busy counters go to 0, rr_ptr goes to 0.
- Fewer candidates than free FUs: unused FUs have fu_issue_valid 0. More candidates than free FUs: unmatched entries wait. Order-fairness is guaranteed by rr_ptr.
- Consistency invariant: rs_dispatch_en[r] && rs_fu_assign[r]==f iff fu_issue_valid[f] && fu_issue_rs_idx[f]==r.
- Implementation: all state updates in one always_ff; matching in always_comb with full default assignments (no latches).

Test Plan:
- Reset release: rst 1 for 2 cycles, rs_ready=8'hFF, fu_enable=2'b11 -> all outputs 0 during reset. First cycle after release: next-cycle rs_dispatch_en=8'h03, rs_fu_assign[0]=0, rs_fu_assign[1]=1, rr_ptr=2.
- Fairness: rs_ready=8'hFF held, all latencies 1, NUM_OF_FU=2 -> successive dispatch sets are {0,1},{2,3},{4,5},{6,7},{0,1}. The masked previous pair never repeats back-to-back.
- Multi-cycle FU: one FU enabled, rs_ready=8'h01, rs_latency[0]=3 with ready held, rs_dispatch_en acted on -> fu_issue_valid pulses at cycles 1,4,7 and fu_busy high for 2 cycles after each issue.
- Latency 0: rs_latency=0 for entries 0 and 1, one FU -> issues on consecutive cycles alternating entries 0 and 1, fu_busy never asserted.
- Enable mask: fu_enable=2'b10, rs_ready=8'h10 -> rs_fu_assign[4]=1, fu_issue_rs_idx[1]=4, fu_issue_valid=2'b10.
- Flush mid-operation: FU busy with busy_cnt=5 and grants pending, flush pulsed -> next cycle all outputs 0, fu_busy=0, rr_ptr=0. Issue resumes the following cycle from RS 0.
